can_tx_scheduler: RTL and testbench

Transmit scheduler between NUM_MB message mailboxes and the single CAN bit-level transmitter. Latches mailbox requests, picks the pending frame with the lowest identifier (CAN priority order), hands it to the transmitter and handles the outcome. Outcomes are success, arbitration loss (re-queue), error (bounded retry) and a watchdog timeout on the transmitter. Sits directly above the transmitter and PHY; one frame is in flight at a time.

---
 rtl/can_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_can_tx_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - lowest-identifier-first transmit scheduler above the CAN bit transmitter
module can_tx_scheduler #(
  parameter int NUM_MB    = 4,
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_MB-1:0]    mb_req,
  input  logic [NUM_MB-1:0]    mb_abort,
  input  logic [NUM_MB*11-1:0] mb_id,
  input  logic [NUM_MB*4-1:0]  mb_len,
  input  logic [NUM_MB*64-1:0] mb_data,
  input  logic                 bus_idle,
  output logic                 tx_start,
  output logic [10:0]          tx_id,
  output logic [3:0]           tx_len,
  output logic [63:0]          tx_data,
  input  logic                 tx_ok,
  input  logic                 tx_arb_lost,
  input  logic                 tx_err,
  output logic [NUM_MB-1:0]    mb_done,
  output logic [NUM_MB-1:0]    mb_fail,
  output logic                 busy,
  output logic [2:0]           cur_mb
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_START, S_WAIT} state_t;

  state_t             state, state_nx;
  logic [NUM_MB-1:0]  pending, pending_nx;
  logic [3:0]         retry [NUM_MB];
  logic [WD_W-1:0]    wdog;

  logic               sel_found;
  logic [2:0]         sel_idx;
  logic [10:0]        sel_id;
  logic [3:0]         sel_len;
  logic [63:0]        sel_data;

  logic [NUM_MB-1:0]  flight;
  logic [NUM_MB-1:0]  req_eff, abort_eff;
  logic [3:0]         cur_retry, retry_inc;
  logic               in_wait, wd_expired;
  logic               res_err, res_arb, res_ok, fail_now;

  assign tx_start = (state == S_START);
  assign busy     = (state != S_IDLE);

  // Arbitration: lowest pending identifier wins, ties resolved toward the lower mailbox index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    sel_len   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending[i] && (!sel_found || (mb_id[11*i +: 11] < sel_id))) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_id    = mb_id[11*i +: 11];
        sel_len   = mb_len[4*i +: 4];
        sel_data  = mb_data[64*i +: 64];
      end
    end
  end

  // One-hot of the mailbox being transmitted; in SELECT that is the one being chosen right now.
  always_comb begin
    flight    = '0;
    cur_retry = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if ((state == S_SELECT && sel_found && sel_idx == 3'(i)) ||
          ((state == S_START || state == S_WAIT) && cur_mb == 3'(i))) begin
        flight[i] = 1'b1;
      end
      if (cur_mb == 3'(i)) begin
        cur_retry = retry[i];
      end
    end
  end

  assign in_wait    = (state == S_WAIT);
  assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));
  assign res_err    = in_wait && (tx_err || wd_expired);
  assign res_arb    = in_wait && !res_err && tx_arb_lost;
  assign res_ok     = in_wait && !res_err && !tx_arb_lost && tx_ok;
  assign retry_inc  = cur_retry + 4'd1;
  assign fail_now   = res_err && (retry_inc == 4'(MAX_RETRY));

  // Request/abort bookkeeping; a request beats an abort in the same cycle, the in-flight mailbox is untouchable.
  always_comb begin
    req_eff    = mb_req & ~flight;
    abort_eff  = mb_abort & ~flight & ~mb_req;
    pending_nx = (pending | req_eff) & ~abort_eff;
    if (res_ok || fail_now) begin
      pending_nx = pending_nx & ~flight;
    end
  end

  // Next-state logic; IDLE looks at this cycle's requests so a fresh request is selected next cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if ((|pending_nx) && bus_idle) state_nx = S_SELECT;
      S_SELECT: state_nx = sel_found ? S_START : S_IDLE;
      S_START:  state_nx = S_WAIT;
      S_WAIT:   if (res_err || res_arb || res_ok) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State, pending set, watchdog, latched frame fields and outcome pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pending <= '0;
      wdog    <= '0;
      cur_mb  <= '0;
      tx_id   <= '0;
      tx_len  <= '0;
      tx_data <= '0;
      mb_done <= '0;
      mb_fail <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      mb_done <= res_ok   ? flight : '0;
      mb_fail <= fail_now ? flight : '0;
      if (state == S_START) begin
        wdog <= '0;
      end else if (state == S_WAIT) begin
        wdog <= wdog + 1'b1;
      end
      if (state == S_SELECT && sel_found) begin
        cur_mb  <= sel_idx;
        tx_id   <= sel_id;
        tx_len  <= (sel_len > 4'd8) ? 4'd8 : sel_len;
        tx_data <= sel_data;
      end
    end
  end

  // Per-mailbox error attempt counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MB; i++) begin
      if (rst || abort_eff[i]) begin
        retry[i] <= '0;
      end else if (flight[i] && (res_ok || fail_now)) begin
        retry[i] <= '0;
      end else if (flight[i] && res_err) begin
        retry[i] <= retry_inc;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - randomized scoreboard bench for can_tx_scheduler
module tb_can_tx_scheduler;

  localparam int NUM_MB    = 4;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 128;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_MB-1:0]    mb_req, mb_abort;
  logic [NUM_MB*11-1:0] mb_id;
  logic [NUM_MB*4-1:0]  mb_len;
  logic [NUM_MB*64-1:0] mb_data;
  logic                 bus_idle;
  logic                 tx_start;
  logic [10:0]          tx_id;
  logic [3:0]           tx_len;
  logic [63:0]          tx_data;
  logic                 tx_ok, tx_arb_lost, tx_err;
  logic [NUM_MB-1:0]    mb_done, mb_fail;
  logic                 busy;
  logic [2:0]           cur_mb;

  can_tx_scheduler #(.NUM_MB(NUM_MB), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mb_req(mb_req), .mb_abort(mb_abort), .mb_id(mb_id),
    .mb_len(mb_len), .mb_data(mb_data), .bus_idle(bus_idle), .tx_start(tx_start),
    .tx_id(tx_id), .tx_len(tx_len), .tx_data(tx_data), .tx_ok(tx_ok),
    .tx_arb_lost(tx_arb_lost), .tx_err(tx_err), .mb_done(mb_done), .mb_fail(mb_fail),
    .busy(busy), .cur_mb(cur_mb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          mb;
    logic [10:0] id;
    logic [3:0]  len;
    logic [63:0] data;
    int          at;
  } start_t;

  typedef struct {
    logic [NUM_MB-1:0] done;
    logic [NUM_MB-1:0] fail;
    int                at;
  } result_t;

  start_t  sq[$];
  result_t rq[$];

  int total = 0;
  int bad   = 0;

  // reference model: which mailboxes hold a frame, their error counts and frame contents
  bit          mp [NUM_MB];
  int          mr [NUM_MB];
  logic [10:0] mid [NUM_MB];
  logic [3:0]  mlen [NUM_MB];
  logic [63:0] mdat [NUM_MB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // monitor: compare every tx_start and every done/fail pulse against the queued expectations
  always @(negedge clk) begin
    start_t  es;
    result_t er;
    if (tx_start) begin
      if (sq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_start at cycle %0d cur_mb=%0d id=%0h", cyc, cur_mb, tx_id);
      end else begin
        es = sq.pop_front();
        chk("start_cycle", 64'(cyc), 64'(es.at));
        chk("start_mb", 64'(cur_mb), 64'(es.mb));
        chk("start_id", 64'(tx_id), 64'(es.id));
        chk("start_len", 64'(tx_len), 64'(es.len));
        chk("start_data", tx_data, es.data);
        chk("start_busy", 64'(busy), 64'd1);
      end
    end
    if ((|mb_done) || (|mb_fail)) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result at cycle %0d done=%b fail=%b", cyc, mb_done, mb_fail);
      end else begin
        er = rq.pop_front();
        chk("result_cycle", 64'(cyc), 64'(er.at));
        chk("result_done", 64'(mb_done), 64'(er.done));
        chk("result_fail", 64'(mb_fail), 64'(er.fail));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    mb_req      = '0;
    mb_abort    = '0;
    tx_ok       = 1'b0;
    tx_arb_lost = 1'b0;
    tx_err      = 1'b0;
  endtask

  task automatic set_mb(input int i, input logic [10:0] id, input logic [3:0] len, input logic [63:0] d);
    mid[i]  = id;
    mlen[i] = len;
    mdat[i] = d;
    mb_id[11*i +: 11]  = id;
    mb_len[4*i +: 4]   = len;
    mb_data[64*i +: 64] = d;
  endtask

  // drive req/abort pulses for the current cycle and update the model; the in-flight mailbox ignores both
  task automatic apply_ra(input logic [NUM_MB-1:0] req, input logic [NUM_MB-1:0] abt, input int flight, input bit rnd);
    for (int i = 0; i < NUM_MB; i++) begin
      if (i == flight) continue;
      if (req[i]) begin
        if (!mp[i] && rnd)
          set_mb(i, 11'($urandom_range(0, 15) * 100), 4'($urandom_range(0, 15)),
                 {$urandom(), $urandom()});
        mp[i] = 1'b1;
      end else if (abt[i]) begin
        mp[i] = 1'b0;
        mr[i] = 0;
      end
    end
    mb_req   = req;
    mb_abort = abt;
  endtask

  function automatic int pick();
    int best = -1;
    for (int i = 0; i < NUM_MB; i++)
      if (mp[i] && (best < 0 || mid[i] < mid[best])) best = i;
    return best;
  endfunction

  function automatic logic [NUM_MB-1:0] sparse();
    return NUM_MB'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
  endfunction

  // raise bus_idle (with optional requests) while idle; returns the tx_start cycle and the chosen mailbox
  task automatic launch(input logic [NUM_MB-1:0] req, input bit rnd, output int s, output int f);
    start_t e;
    apply_ra(req, '0, -1, rnd);
    f = pick();
    s = cyc + 2;
    if (f >= 0) begin
      e.mb   = f;
      e.id   = mid[f];
      e.len  = (mlen[f] > 4'd8) ? 4'd8 : mlen[f];
      e.data = mdat[f];
      e.at   = s;
      sq.push_back(e);
    end
    bus_idle = 1'b1;
    next();
    bus_idle = 1'b0;
    next();
    next();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_MB; i++) begin
      mp[i] = 1'b0;
      mr[i] = 0;
    end
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(mb_done), 64'd0);
    chk("rst_fail", 64'(mb_fail), 64'd0);
    chk("rst_cur_mb", 64'(cur_mb), 64'd0);
    chk("rst_tx_id", 64'(tx_id), 64'd0);
    chk("rst_tx_len", 64'(tx_len), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    next();
  endtask

  // kind: 0 ok, 1 arb lost, 2 error, 3 watchdog timeout, 4 all three pulses, 5 reset mid-frame
  task automatic finish_frame(input int kind, input int d, input int s, input int f, input bit noise);
    result_t e;
    int r;
    for (int j = 0; j < d; j++) begin
      if (noise) apply_ra(sparse(), sparse(), f, 1'b1);
      next();
    end
    if (kind == 5) begin
      do_reset();
      return;
    end
    if (kind == 3) begin
      while (cyc < s + TIMEOUT) next();
    end else if (noise) begin
      apply_ra(sparse(), sparse(), f, 1'b1);
    end
    r = cyc;
    tx_ok       = (kind == 0 || kind == 4);
    tx_arb_lost = (kind == 1 || kind == 4);
    tx_err      = (kind == 2 || kind == 4);
    e.done = '0;
    e.fail = '0;
    e.at   = r + 1;
    if (f >= 0) begin
      if (kind == 0) begin
        e.done[f] = 1'b1;
        mp[f] = 1'b0;
        mr[f] = 0;
        rq.push_back(e);
      end else if (kind != 1) begin
        mr[f]++;
        if (mr[f] == MAX_RETRY) begin
          e.fail[f] = 1'b1;
          mp[f] = 1'b0;
          mr[f] = 0;
          rq.push_back(e);
        end
      end
    end
    next();
    @(negedge clk);
    chk("busy_after_result", 64'(busy), 64'd0);
    next();
  endtask

  initial begin
    int s, f, kind, roll;
    rst = 1'b1; bus_idle = 1'b0;
    mb_req = '0; mb_abort = '0; mb_id = '0; mb_len = '0; mb_data = '0;
    tx_ok = 1'b0; tx_arb_lost = 1'b0; tx_err = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      mp[i] = 1'b0; mr[i] = 0; mid[i] = '0; mlen[i] = '0; mdat[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // single frame with bus already idle
    bus_idle = 1'b1;
    set_mb(2, 11'h123, 4'd8, 64'h0123456789ABCDEF);
    launch(4'b0100, 1'b0, s, f);
    finish_frame(0, 100, s, f, 1'b0);

    // priority: equal ids tie toward the lower index
    set_mb(0, 11'h300, 4'd2, 64'h11);
    set_mb(1, 11'h100, 4'd12, 64'h22);
    set_mb(3, 11'h100, 4'd5, 64'h33);
    launch(4'b1011, 1'b0, s, f); finish_frame(0, 4, s, f, 1'b0);
    launch(4'b0000, 1'b0, s, f); finish_frame(0, 4, s, f, 1'b0);
    launch(4'b0000, 1'b0, s, f); finish_frame(0, 4, s, f, 1'b0);

    // retry exhaustion
    set_mb(1, 11'h0AA, 4'd1, 64'h5A);
    launch(4'b0010, 1'b0, s, f); finish_frame(2, 3, s, f, 1'b0);
    launch(4'b0000, 1'b0, s, f); finish_frame(2, 3, s, f, 1'b0);
    launch(4'b0000, 1'b0, s, f); finish_frame(2, 3, s, f, 1'b0);

    // arbitration loss with a higher-priority request arriving during WAIT
    set_mb(0, 11'h200, 4'd3, 64'h77);
    launch(4'b0001, 1'b0, s, f);
    set_mb(2, 11'h050, 4'd4, 64'h99);
    apply_ra(4'b0100, '0, f, 1'b0);
    next();
    finish_frame(1, 2, s, f, 1'b0);
    launch(4'b0000, 1'b0, s, f); finish_frame(0, 2, s, f, 1'b0);
    launch(4'b0000, 1'b0, s, f); finish_frame(0, 2, s, f, 1'b0);

    // timeout, abort on in-flight ignored, abort on pending removes it
    set_mb(3, 11'h010, 4'd0, 64'h0);
    set_mb(1, 11'h020, 4'd6, 64'h66);
    launch(4'b1010, 1'b0, s, f);
    apply_ra('0, 4'b1010, f, 1'b0);
    next();
    finish_frame(3, 0, s, f, 1'b0);
    launch(4'b0000, 1'b0, s, f); finish_frame(0, 2, s, f, 1'b0);

    // reset in the middle of WAIT, then a normal frame
    set_mb(0, 11'h111, 4'd7, 64'hABCD);
    launch(4'b0001, 1'b0, s, f);
    finish_frame(5, 5, s, f, 1'b0);
    set_mb(0, 11'h222, 4'd8, 64'hFEED);
    launch(4'b0001, 1'b0, s, f); finish_frame(0, 3, s, f, 1'b0);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(1, 4)) begin
        apply_ra(sparse(), sparse(), -1, 1'b1);
        tx_ok       = ($urandom_range(0, 9) == 0);
        tx_err      = ($urandom_range(0, 9) == 0);
        tx_arb_lost = ($urandom_range(0, 9) == 0);
        next();
      end
      launch(NUM_MB'($urandom_range(0, 15)) | NUM_MB'(1 << $urandom_range(0, NUM_MB - 1)), 1'b1, s, f);
      roll = $urandom_range(0, 99);
      kind = (roll < 35) ? 0 : (roll < 55) ? 1 : (roll < 82) ? 2 : (roll < 90) ? 3 : (roll < 96) ? 4 : 5;
      finish_frame(kind, $urandom_range(0, 20), s, f, 1'b1);
    end

    repeat (4) next();
    chk("start_queue_empty", 64'(sq.size()), 64'd0);
    chk("result_queue_empty", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
